// File: rtl/fpa_share_ctrl.sv
// Round-robin sequencer that time-shares one external combinational FP adder
// among NUM_REQ requesters and returns each sum over a valid/ready channel.
module fpa_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [31:0]            fpa_a,
    output logic [31:0]            fpa_b,
    input  logic [31:0]            fpa_sum,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [31:0]       fpa_a_q, fpa_a_d;
    logic [31:0]       fpa_b_q, fpa_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic [ID_W:0]         pick_s;
    logic                  grant_vld_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic [31:0]           grant_a_s;
    logic [31:0]           grant_b_s;
    logic                  operand_neg_s;
    logic [NUM_REQ-1:0]    req_ready_s;

    // Walk from ptr+NUM_REQ-1 down to ptr so the nearest valid requester wins last.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            res = valid[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
        return ID_W'((int'(idx) + 1) % NUM_REQ);
    endfunction

    // Round-robin arbitration and operand selection for the current grant.
    always_comb begin
        pick_s        = rr_pick(req_valid, rr_ptr_q);
        grant_vld_s   = pick_s[ID_W];
        grant_idx_s   = pick_s[ID_W-1:0];
        grant_a_s     = req_a[{grant_idx_s, 5'd0} +: 32];
        grant_b_s     = req_b[{grant_idx_s, 5'd0} +: 32];
        operand_neg_s = fpa_a_q[31] | fpa_b_q[31];
    end

    // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        fpa_a_d     = fpa_a_q;
        fpa_b_d     = fpa_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        req_ready_s = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    fpa_a_d    = grant_a_s;
                    fpa_b_d    = grant_b_s;
                    grant_id_d = grant_idx_s;
                    rr_ptr_d   = ptr_after(grant_idx_s);
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = grant_id_q;
                // The adder only handles non-negative operands; flag and zero instead.
                if (operand_neg_s) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'h0000_0000;
                end else begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = fpa_sum;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                    if (op_count_q != {CNT_W{1'b1}}) begin
                        op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        op_count_d = op_count_q;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            fpa_a_q     <= 32'h0000_0000;
            fpa_b_q     <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            fpa_a_q     <= fpa_a_d;
            fpa_b_q     <= fpa_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready = req_ready_s;
    assign fpa_a     = fpa_a_q;
    assign fpa_b     = fpa_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// Bench for fpa_share_ctrl: directed stimulus, a transaction-level reference
// model checked every cycle, and literal expectations at key points.
module tb_fpa_share_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic         rsp_ready;

    logic [3:0]   req_ready, s_req_ready;
    logic [31:0]  fpa_a, fpa_b, fpa_sum, s_fpa_a, s_fpa_b, s_fpa_sum;
    logic         rsp_valid, rsp_err, busy, s_rsp_valid, s_rsp_err, s_busy;
    logic [1:0]   rsp_id, s_rsp_id;
    logic [31:0]  rsp_data, s_rsp_data;
    logic [15:0]  op_count;
    logic [1:0]   s_op_count;

    int vectors = 0;
    int miscompares = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the external adder: non-negative normals, truncating.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, e, sh;
        logic [24:0] ma, mb, ms;
        if (a[30:0] == 31'd0) return {1'b0, b[30:0]};
        if (b[30:0] == 31'd0) return {1'b0, a[30:0]};
        if (a[30:23] >= b[30:23]) begin
            ea = a[30:23]; eb = b[30:23];
            ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        end else begin
            ea = b[30:23]; eb = a[30:23];
            ma = {2'b01, b[22:0]}; mb = {2'b01, a[22:0]};
        end
        sh = ea - eb;
        mb = (sh > 8'd24) ? 25'd0 : (mb >> sh);
        ms = ma + mb;
        e  = ea;
        if (ms[24]) begin
            ms = ms >> 1;
            e  = e + 8'd1;
        end
        return {1'b0, e, ms[22:0]};
    endfunction

    assign fpa_sum   = fadd(fpa_a, fpa_b);
    assign s_fpa_sum = fadd(s_fpa_a, s_fpa_b);

    fpa_share_ctrl #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_sum(fpa_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    fpa_share_ctrl #(.NUM_REQ(4), .ID_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a(req_a), .req_b(req_b), .fpa_a(s_fpa_a), .fpa_b(s_fpa_b), .fpa_sum(s_fpa_sum),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy), .op_count(s_op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_rr, m_age, m_cnt, m_g;
    logic [31:0] m_fa, m_fb, m_data;
    logic [1:0]  m_id, m_rid;
    logic        m_err;

    function automatic int pick(input logic [3:0] v, input int ptr);
        logic [1:0] idx;
        for (int off = 0; off < 4; off++) begin
            idx = 2'((ptr + off) % 4);
            if (v[idx]) return int'(idx);
        end
        return -1;
    endfunction

    always_comb m_g = pick(req_valid, m_rr);

    // m_age: 0 = free, 1 = operands on the adder, 2 = response offered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr <= 0; m_age <= 0; m_cnt <= 0;
            m_fa <= 32'd0; m_fb <= 32'd0; m_data <= 32'd0;
            m_id <= 2'd0; m_rid <= 2'd0; m_err <= 1'b0;
        end else if (m_age == 0) begin
            if (m_g >= 0) begin
                m_fa  <= req_a[m_g*32 +: 32];
                m_fb  <= req_b[m_g*32 +: 32];
                m_id  <= 2'(m_g);
                m_rr  <= (m_g + 1) % 4;
                m_age <= 1;
            end
        end else if (m_age == 1) begin
            m_rid  <= m_id;
            m_err  <= m_fa[31] | m_fb[31];
            m_data <= (m_fa[31] | m_fb[31]) ? 32'd0 : fadd(m_fa, m_fb);
            m_age  <= 2;
        end else if (rsp_ready) begin
            m_age <= 0;
            m_err <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0] exp_rdy;
            exp_rdy = (m_age == 0 && m_g >= 0) ? 4'(1 << m_g) : 4'd0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_age != 0));
            chk("fpa_a", fpa_a, m_fa);
            chk("fpa_b", fpa_b, m_fb);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
            chk("rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("op_count", 32'(op_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("sat_req_ready", 32'(s_req_ready), 32'(exp_rdy));
            chk("sat_rsp_valid", 32'(s_rsp_valid), 32'(m_age == 2));
            chk("sat_rsp_data", s_rsp_data, m_data);
            chk("sat_op_count", 32'(s_op_count), 32'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        chk("rsp_arrival", 32'(rsp_valid), 32'd1);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    logic [31:0] one_to_four [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] doubled     [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    initial begin
        rst_n = 1'b1; req_valid = 4'd0; req_a = 128'd0; req_b = 128'd0; rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fpa_a", fpa_a, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step(); step(); rst_n = 1'b1;

        // Single op: 1.0 + 2.0 from requester 0
        set_ops(0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        #1 chk("single_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_fpa_a", fpa_a, 32'h3F800000);
        chk("single_exec_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_data", rsp_data, 32'h40400000);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        step();
        chk("single_done", 32'(rsp_valid), 32'd0);
        chk("single_count", 32'(op_count), 32'd1);
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;

        // Round robin, all 1.5 + 1.5: grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_ops(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(4);
            chk("rr1_id", 32'(rsp_id), 32'(k % 4));
            chk("rr1_data", rsp_data, 32'h40400000);
            if (k == 4) req_valid = 4'h0;
            step();
        end
        chk("rr1_count", 32'(op_count), 32'd5);
        chk("rr1_sat_count", 32'(s_op_count), 32'd3);

        // Round robin with A=B=index+1.0, pointer now at 1
        for (int i = 0; i < 4; i++) set_ops(i, one_to_four[i], one_to_four[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(4);
            chk("rr2_id", 32'(rsp_id), 32'((k + 1) % 4));
            chk("rr2_data", rsp_data, doubled[(k + 1) % 4]);
            if (k == 3) req_valid = 4'h0;
            step();
        end
        chk("rr2_count", 32'(op_count), 32'd9);

        // Backpressure on requester 1 while requester 3 waits
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        wait_rsp(4);
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'h40800000);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_next_ready", 32'(req_ready), 32'h8);
        chk("bp_count", 32'(op_count), 32'd10);
        step();
        req_valid = 4'b0000;
        chk("bp_next_grant", fpa_a, 32'h40800000);
        step();
        chk("bp_next_id", 32'(rsp_id), 32'd3);
        chk("bp_next_data", rsp_data, 32'h41000000);
        step();
        chk("bp_next_count", 32'(op_count), 32'd11);

        // Negative operand on requester 2
        set_ops(2, 32'hBF800000, 32'h3F800000);
        req_valid = 4'b0100;
        wait_rsp(4);
        req_valid = 4'b0000;
        chk("sign_err", 32'(rsp_err), 32'd1);
        chk("sign_data", rsp_data, 32'd0);
        chk("sign_id", 32'(rsp_id), 32'd2);
        step();
        chk("sign_count", 32'(op_count), 32'd12);
        chk("sign_err_clear", 32'(rsp_err), 32'd0);

        // Reset while requester 1 is in the adder cycle
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        chk("rexec_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rexec_busy_clr", 32'(busy), 32'd0);
        chk("rexec_count_clr", 32'(op_count), 32'd0);
        step(); step(); rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        req_valid = 4'b0101;
        #1 chk("rexec_ptr_zero", 32'(req_ready), 32'h1);

        // Five ops alternating 0 and 2; the 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            wait_rsp(4);
            chk("sat_id", 32'(rsp_id), 32'((k % 2 == 1) ? 2 : 0));
            chk("sat_err", 32'(rsp_err), 32'(k % 2));
            if (k == 4) req_valid = 4'b0000;
            step();
        end
        chk("sat_main_count", 32'(op_count), 32'd5);
        chk("sat_small_count", 32'(s_op_count), 32'd3);

        // Reset while a response is being held
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        step();
        chk("rresp_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rresp_async_clr", 32'(rsp_valid), 32'd0);
        chk("rresp_sat_clr", 32'(s_op_count), 32'd0);
        step(); rst_n = 1'b1; rsp_ready = 1'b1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
